// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory image loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CNT_LO,
    CNT_HI,
    DATA,
    CHK,
    DONE,
    ERR
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_OVF  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

endpackage

// File: rtl/imem_loader_timeout.sv
// Idle-cycle counter: counts enabled cycles since the last clear and flags
// the cycle on which the count would reach TIMEOUT_CYC.
module loader_timeout #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: sync, 16-bit word count, little-endian
// words, XOR checksum; releases the CPU only after a verified image.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int         INST_W      = 26,
  parameter int         ADDR_W      = 10,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [INST_W-1:0] imem_wdata,
  output logic              imem_we,
  output logic              cpu_rst_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   widx_q, widx_d;
  logic [1:0]        bidx_q, bidx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic              imem_we_q, imem_we_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [INST_W-1:0] imem_wdata_q, imem_wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              xfer, active, tmo_expired, restart;
  logic [31:0]       new_word;
  logic [15:0]       n_words;
  logic [ADDR_W:0]   widx_inc;

  assign in_ready = !rst;
  assign xfer     = in_valid && !rst;
  assign active   = (state_q == CNT_LO) || (state_q == CNT_HI) ||
                    (state_q == DATA)   || (state_q == CHK);
  assign restart  = xfer && (in_data == SYNC_BYTE);
  assign new_word = {in_data, word_q[31:8]};
  assign n_words  = {in_data, cnt_q[7:0]};
  assign widx_inc = widx_q + {{ADDR_W{1'b0}}, 1'b1};

  loader_timeout #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_tmo (
    .clk     (clk),
    .rst     (rst),
    .clr     (xfer || !active),
    .en      (active),
    .expired (tmo_expired)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    widx_d       = widx_q;
    bidx_d       = bidx_q;
    word_d       = word_q;
    csum_d       = csum_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;
    hold_d       = hold_q;
    done_d       = done_q;
    err_d        = err_q;
    err_code_d   = err_code_q;

    if (active && xfer) csum_d = csum_q ^ in_data;

    case (state_q)
      IDLE, DONE, ERR: begin
        if (restart) begin
          state_d     = CNT_LO;
          csum_d      = 8'h00;
          bidx_d      = 2'd0;
          widx_d      = '0;
          imem_addr_d = '0;
          hold_d      = 1'b1;
          done_d      = 1'b0;
          err_d       = 1'b0;
          err_code_d  = ERR_NONE;
        end
      end
      CNT_LO: if (xfer) begin
        cnt_d   = {8'h00, in_data};
        state_d = CNT_HI;
      end
      CNT_HI: if (xfer) begin
        cnt_d = n_words;
        if ({1'b0, n_words} > MAX_WORDS) begin
          state_d    = ERR;
          err_d      = 1'b1;
          err_code_d = ERR_OVF;
        end else if (n_words == 16'd0) begin
          state_d = CHK;
        end else begin
          state_d = DATA;
        end
      end
      DATA: if (xfer) begin
        word_d = new_word;
        bidx_d = bidx_q + 2'd1;
        if (bidx_q == 2'd3) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = widx_q[ADDR_W-1:0];
          imem_wdata_d = new_word[INST_W-1:0];
          widx_d       = widx_inc;
          if (16'(widx_inc) == cnt_q) state_d = CHK;
        end
      end
      CHK: if (xfer) begin
        if (in_data == csum_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b0;
        end else begin
          state_d    = ERR;
          err_d      = 1'b1;
          err_code_d = ERR_CSUM;
        end
      end
      default: state_d = IDLE;
    endcase

    // Idle too long mid-image; any partial word is simply abandoned.
    if (active && tmo_expired) begin
      state_d    = ERR;
      err_d      = 1'b1;
      err_code_d = ERR_TMO;
      hold_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      widx_q       <= '0;
      bidx_q       <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      widx_q       <= widx_d;
      bidx_q       <= bidx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign imem_we      = imem_we_q;
  assign imem_addr    = imem_addr_q;
  assign imem_wdata   = imem_wdata_q;
  assign cpu_rst_hold = hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign err_code     = err_code_q;

endmodule
